// File: rtl/blf_expand_ctrl.sv
// Blowfish/bcrypt key-schedule sequencer: drives encipher 521 times and
// rewrites P[0..17] then S[0..1023] from the chained ciphertext pairs.
//
// Ports:
//   clk, reset_l             clock, synchronous active-low reset
//   start, salt_en, salt     run request and salt (latched at start)
//   enc_start, enc_xl/xr     encipher launch pulse and plaintext pair
//   enc_xl_out/xr_out, done  encipher result pair and completion
//   p_we/p_waddr             P-array write port
//   s_we/s_waddr             S-box write port
//   wdata                    shared write data
//   busy, done               run status, completion pulse
module blf_expand_ctrl #(
  parameter int P_WORDS    = 18,
  parameter int S_WORDS    = 1024,
  parameter int SALT_WORDS = 4
) (
  input  logic         clk,
  input  logic         reset_l,
  input  logic         start,
  input  logic         salt_en,
  input  logic [127:0] salt,
  output logic         enc_start,
  output logic [31:0]  enc_xl,
  output logic [31:0]  enc_xr,
  input  logic [31:0]  enc_xl_out,
  input  logic [31:0]  enc_xr_out,
  input  logic         enc_done,
  output logic         p_we,
  output logic [4:0]   p_waddr,
  output logic         s_we,
  output logic [9:0]   s_waddr,
  output logic [31:0]  wdata,
  output logic         busy,
  output logic         done
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] ENC_START = 3'd1;
  localparam logic [2:0] ENC_WAIT  = 3'd2;
  localparam logic [2:0] WR_L      = 3'd3;
  localparam logic [2:0] WR_R      = 3'd4;
  localparam logic [2:0] DONE      = 3'd5;

  localparam logic [8:0] P_LAST = 9'(P_WORDS / 2 - 1);
  localparam logic [8:0] S_LAST = 9'(S_WORDS / 2 - 1);
  localparam logic [1:0] S_MASK = 2'(SALT_WORDS - 1);

  logic [2:0]   state;
  logic         phase;
  logic [8:0]   blk;
  logic [1:0]   sidx;
  logic [31:0]  data_l;
  logic [31:0]  data_r;
  logic [127:0] salt_q;
  logic         salt_en_q;

  function automatic logic [31:0] salt_word(
    input logic [127:0] s,
    input logic [1:0]   idx
  );
    logic [31:0] w;
    unique case (idx)
      2'd0:    w = s[127:96];
      2'd1:    w = s[95:64];
      2'd2:    w = s[63:32];
      default: w = s[31:0];
    endcase
    return w;
  endfunction

  always_ff @(posedge clk) begin
    if (!reset_l) begin
      state     <= IDLE;
      phase     <= 1'b0;
      blk       <= '0;
      sidx      <= '0;
      data_l    <= '0;
      data_r    <= '0;
      salt_q    <= '0;
      salt_en_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            salt_q    <= salt;
            salt_en_q <= salt_en;
            data_l    <= '0;
            data_r    <= '0;
            blk       <= '0;
            sidx      <= '0;
            phase     <= 1'b0;
            state     <= ENC_START;
          end
        end
        ENC_START: state <= ENC_WAIT;
        ENC_WAIT: begin
          if (enc_done) begin
            data_l <= enc_xl_out;
            data_r <= enc_xr_out;
            state  <= WR_L;
          end
        end
        WR_L: state <= WR_R;
        WR_R: begin
          // salt pairs keep rotating across the P/S boundary
          sidx <= (sidx + 2'd2) & S_MASK;
          if (!phase && blk == P_LAST) begin
            phase <= 1'b1;
            blk   <= '0;
            state <= ENC_START;
          end else if (phase && blk == S_LAST) begin
            state <= DONE;
          end else begin
            blk   <= blk + 9'd1;
            state <= ENC_START;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  logic       wr;
  logic [9:0] waddr;
  logic [31:0] sl;
  logic [31:0] sr;

  assign wr    = (state == WR_L) || (state == WR_R);
  assign waddr = {blk, state == WR_R};
  assign sl    = salt_en_q ? salt_word(salt_q, sidx) : 32'd0;
  assign sr    = salt_en_q ? salt_word(salt_q, sidx + 2'd1) : 32'd0;

  assign enc_start = (state == ENC_START);
  assign enc_xl    = enc_start ? (data_l ^ sl) : 32'd0;
  assign enc_xr    = enc_start ? (data_r ^ sr) : 32'd0;

  assign p_we    = wr && !phase;
  assign s_we    = wr && phase;
  assign p_waddr = p_we ? waddr[4:0] : 5'd0;
  assign s_waddr = s_we ? waddr : 10'd0;
  assign wdata   = (state == WR_L) ? data_l :
                   (state == WR_R) ? data_r : 32'd0;

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_blf_expand_ctrl.sv
// Self-checking bench for blf_expand_ctrl: table vectors, random runs
// against a block-level reference model, and reset/start corner cases.
module tb_blf_expand_ctrl;

  logic         clk = 1'b0;
  logic         reset_l = 1'b0;
  logic         start = 1'b0;
  logic         salt_en = 1'b0;
  logic [127:0] salt = '0;
  logic         enc_start;
  logic [31:0]  enc_xl, enc_xr;
  logic [31:0]  enc_xl_out = '0, enc_xr_out = '0;
  logic         enc_done = 1'b0;
  logic         p_we, s_we;
  logic [4:0]   p_waddr;
  logic [9:0]   s_waddr;
  logic [31:0]  wdata;
  logic         busy, done;

  always #5 clk = ~clk;

  blf_expand_ctrl dut (
    .clk(clk), .reset_l(reset_l), .start(start),
    .salt_en(salt_en), .salt(salt),
    .enc_start(enc_start), .enc_xl(enc_xl), .enc_xr(enc_xr),
    .enc_xl_out(enc_xl_out), .enc_xr_out(enc_xr_out),
    .enc_done(enc_done),
    .p_we(p_we), .p_waddr(p_waddr),
    .s_we(s_we), .s_waddr(s_waddr),
    .wdata(wdata), .busy(busy), .done(done)
  );

  // encipher stub: out = in + k, result lat cycles after enc_start
  logic [31:0] ka = 0, kb = 0, cxl = 0, cxr = 0;
  int lat = 1;
  int cnt = 0;
  bit inj = 0;
  always @(negedge clk) begin
    enc_done = 1'b0;
    if (!reset_l) cnt = 0;
    else begin
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          enc_done = 1'b1;
          enc_xl_out = cxl + ka;
          enc_xr_out = cxr + kb;
        end
      end
      if (enc_start) begin
        cnt = lat; cxl = enc_xl; cxr = enc_xr;
      end
      if (inj && (p_we || s_we)) begin
        enc_done = 1'b1;
        enc_xl_out = 32'hdead_beef;
        enc_xr_out = 32'hbad0_f00d;
      end
    end
  end

  // bus monitor
  logic [42:0] wq[$];
  logic [63:0] xq[$];
  int n_enc = 0, n_done = 0, n_busy = 0, n_p = 0, n_s = 0, n_bad = 0;
  always @(negedge clk) begin
    if (p_we) begin wq.push_back({1'b0, 5'd0, p_waddr, wdata}); n_p++; end
    if (s_we) begin wq.push_back({1'b1, s_waddr, wdata}); n_s++; end
    if (p_we && s_we) n_bad++;
    if (!p_we && p_waddr != 0) n_bad++;
    if (!s_we && s_waddr != 0) n_bad++;
    if (!p_we && !s_we && wdata != 0) n_bad++;
    if (enc_start) begin n_enc++; xq.push_back({enc_xl, enc_xr}); end
    if (done) n_done++;
    if (busy) n_busy++;
  end

  int checks = 0, failures = 0;
  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // reference: one entry per block, written straight from the schedule rules
  logic [42:0] ew[$];
  logic [63:0] ex[$];
  task automatic build(input bit se, input logic [127:0] s,
                       input logic [31:0] a, input logic [31:0] b);
    logic [31:0] l, r, xl, xr;
    int si;
    ew.delete(); ex.delete();
    l = 0; r = 0; si = 0;
    for (int n = 0; n < 521; n++) begin
      xl = l ^ (se ? s[127-32*si -: 32] : 32'd0);
      xr = r ^ (se ? s[127-32*(si+1) -: 32] : 32'd0);
      ex.push_back({xl, xr});
      l = xl + a; r = xr + b;
      if (n < 9) begin
        ew.push_back({1'b0, 10'(2*n), l});
        ew.push_back({1'b0, 10'(2*n+1), r});
      end else begin
        ew.push_back({1'b1, 10'(2*(n-9)), l});
        ew.push_back({1'b1, 10'(2*(n-9)+1), r});
      end
      si = (si + 2) % 4;
    end
  endtask

  task automatic run(input string tag, input bit se, input logic [127:0] s,
                     input logic [31:0] a, input logic [31:0] b,
                     input int l, input bit hold,
                     output logic [127:0] p4);
    int wb, xb, e0, d0, b0, pc0, sc0, bad0, tmo, wn, xn, bi;
    int en, dn, bn, pn, sn, badn;
    build(se, s, a, b);
    ka = a; kb = b; lat = l;
    wb = wq.size(); xb = xq.size(); e0 = n_enc; d0 = n_done;
    b0 = n_busy; pc0 = n_p; sc0 = n_s; bad0 = n_bad;
    salt_en = se; salt = s; start = 1'b1;
    @(negedge clk); #1;
    start = hold;
    salt = ~s; salt_en = ~se;
    tmo = 0;
    while (n_done == d0 && tmo < 20000) begin
      @(negedge clk); #1; tmo++;
    end
    chk({tag, "_timeout"}, tmo < 20000, 1);
    wn = wq.size() - wb; xn = xq.size() - xb;
    en = n_enc - e0; dn = n_done - d0; bn = n_busy - b0;
    pn = n_p - pc0; sn = n_s - sc0; badn = n_bad - bad0;
    chk({tag, "_enc_cnt"}, en, 521);
    chk({tag, "_p_cnt"}, pn, 18);
    chk({tag, "_s_cnt"}, sn, 1024);
    chk({tag, "_done_cnt"}, dn, 1);
    chk({tag, "_busy_cyc"}, bn, 521 * (3 + l) + 1);
    chk({tag, "_bus_rules"}, badn, 0);
    bi = -1;
    for (int i = 0; i < 1042 && i < wn; i++)
      if (bi < 0 && wq[wb+i] !== ew[i]) bi = i;
    chk({tag, "_wr_len"}, wn, 1042);
    chk({tag, "_wr_first_bad"}, bi, -1);
    bi = -1;
    for (int i = 0; i < 521 && i < xn; i++)
      if (bi < 0 && xq[xb+i] !== ex[i]) bi = i;
    chk({tag, "_enc_first_bad"}, bi, -1);
    p4 = '0;
    if (wn >= 1042) begin
      p4 = {wq[wb][31:0], wq[wb+1][31:0], wq[wb+2][31:0], wq[wb+3][31:0]};
      chk({tag, "_last_p"}, wq[wb+17][42:32], {1'b0, 10'd17});
      chk({tag, "_first_s"}, wq[wb+18][42:32], {1'b1, 10'd0});
      chk({tag, "_last_s"}, wq[wb+1041][42:32], {1'b1, 10'd1023});
    end
    @(negedge clk); #1;
    chk({tag, "_idle_after"}, {busy, done}, 0);
    if (hold) begin
      @(negedge clk); #1;
      chk({tag, "_restart"}, {enc_start, busy}, 2'b11);
      start = 1'b0; reset_l = 1'b0;
      @(negedge clk); #1;
      reset_l = 1'b1;
    end
  endtask

  typedef struct {
    bit           se;
    logic [127:0] salt;
    logic [31:0]  a, b;
    int           lat;
    logic [127:0] p4;
  } vec_t;

  vec_t vt[3];
  logic [127:0] p4;
  logic [127:0] s128;
  int e0, w0, d0, tmo;

  initial begin
    s128 = 128'h00000001_00000002_00000003_00000004;
    vt[0] = '{0, s128, 32'd1, 32'd2, 3,
              {32'd1, 32'd2, 32'd2, 32'd4}};
    vt[1] = '{1, s128, 32'd0, 32'd0, 3,
              {32'd1, 32'd2, 32'd2, 32'd6}};
    vt[2] = '{1, s128, 32'd1, 32'd2, 1,
              {32'd2, 32'd4, 32'd2, 32'd2}};

    // reset held with start high
    start = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    e0 = n_enc;
    for (int i = 0; i < 4; i++) begin
      chk("reset_outs", {enc_start, enc_xl, enc_xr, p_we, p_waddr, s_we,
                         s_waddr, wdata, busy, done}, 0);
      @(negedge clk); #1;
    end
    chk("reset_no_enc", n_enc - e0, 0);
    start = 1'b0; reset_l = 1'b1;
    @(negedge clk); #1;

    for (int i = 0; i < 3; i++) begin
      run($sformatf("vec%0d", i), vt[i].se, vt[i].salt, vt[i].a,
          vt[i].b, vt[i].lat, 0, p4);
      chk($sformatf("vec%0d_p0_3", i), p4, vt[i].p4);
    end

    for (int i = 0; i < 3; i++)
      run($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)),
          {$urandom, $urandom, $urandom, $urandom}, $urandom, $urandom,
          int'($urandom_range(1, 4)), 0, p4);

    // start held high, spurious enc_done during writes
    inj = 1;
    run("hold", 1, s128, 32'd1, 32'd2, 2, 1, p4);
    chk("hold_p0_3", p4, vt[2].p4);
    inj = 0;

    // abort in ENC_WAIT, phase S, blk 100
    ka = 1; kb = 2; lat = 6;
    salt_en = 0; start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    w0 = n_s; tmo = 0;
    while (!(n_s - w0 >= 200 && enc_start) && tmo < 20000) begin
      @(negedge clk); #1; tmo++;
    end
    chk("abort_reach", tmo < 20000, 1);
    @(negedge clk); #1;
    reset_l = 1'b0;
    @(negedge clk); #1;
    reset_l = 1'b1;
    chk("abort_idle", {busy, done, p_we, s_we}, 0);
    w0 = wq.size(); d0 = n_done; e0 = n_enc;
    repeat (12) @(negedge clk);
    #1;
    chk("abort_quiet", {32'(wq.size() - w0), 32'(n_done - d0),
                        32'(n_enc - e0)}, 0);
    w0 = wq.size();
    run("fresh", 0, s128, 32'd1, 32'd2, 2, 0, p4);
    chk("fresh_p0_3", p4, vt[0].p4);
    if (wq.size() > w0)
      chk("fresh_first", wq[w0][42:32], {1'b0, 10'd0});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
